sdf_stage_ctrl: RTL and testbench

//  Sequencer for one radix-2 single-path delay-feedback (SDF) FFT stage.

---
 rtl/fft_pkg.sv | 21 ++
 rtl/sdf_stage_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sdf_stage_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the SDF FFT pipeline.
//   sdf_state_t : stage-controller FSM encoding
//   idx_w()     : bits needed to index a delay line of the given depth
//   cnt_w()     : bits for a sample counter spanning one full butterfly (2*depth)
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } sdf_state_t;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(2 * depth);
  endfunction

endpackage

// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one radix-2 single-path delay-feedback FFT stage.
// Tracks sample position against the free-running INDEX-deep delay line,
// enforces gap-free frames and drains the delay line after the last frame.
//
// Ports
//   clk        stage clock
//   rst        asynchronous, active-high reset
//   in_valid   sample present on the stage input
//   in_last    last sample of the stream (qualified by in_valid)
//   bf_sel     1 = butterfly half, 0 = fill half
//   out_sel    1 = output takes butterfly sum, 0 = twiddled delay-line output
//   out_valid  stage output valid
//   tw_addr    twiddle ROM address for the delay-line output sample
//   busy       controller not idle
//   done       one-cycle pulse after the final flush cycle
//   err        one-cycle pulse after a protocol violation
//
// state | meaning
// IDLE  | waiting for the first sample of a stream
// RUN   | accepting contiguous samples, cnt tracks position in the frame
// FLUSH | no input, draining the last frame's diffs for INDEX cycles
module sdf_stage_ctrl
  import fft_pkg::*;
#(
  parameter int INDEX     = 16,
  parameter int TW_STRIDE = 1,
  parameter int TW_AW     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             bf_sel,
  output logic             out_sel,
  output logic             out_valid,
  output logic [TW_AW-1:0] tw_addr,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int IW = idx_w(INDEX);
  localparam int CW = cnt_w(INDEX);
  // Product width wide enough to hold (INDEX-1)*TW_STRIDE before truncation.
  localparam int PW = IW + $clog2(TW_STRIDE) + 1;

  localparam logic [CW-1:0] CNT_FRAME_LAST = CW'(2 * INDEX - 1);
  localparam logic [CW-1:0] CNT_FLUSH_LAST = CW'(INDEX - 1);

  sdf_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          primed, primed_nxt;
  logic          done_nxt, err_nxt;

  logic          ph;
  logic [PW-1:0] tw_prod;

  assign ph      = cnt[IW];
  assign tw_prod = PW'(cnt[IW-1:0]) * PW'(TW_STRIDE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      primed <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      primed <= primed_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    primed_nxt = primed;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    bf_sel     = 1'b0;
    out_sel    = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_last) begin
            // A one-sample stream can never complete a butterfly.
            err_nxt = 1'b1;
          end else begin
            // This sample occupies cnt=0; the next one is cnt=1.
            state_nxt = RUN;
            cnt_nxt   = CW'(1);
          end
        end
      end

      RUN: begin
        busy = 1'b1;
        if (!in_valid) begin
          err_nxt    = 1'b1;
          state_nxt  = IDLE;
          cnt_nxt    = '0;
          primed_nxt = 1'b0;
        end else begin
          bf_sel    = ph;
          out_sel   = ph;
          // Fill half carries the previous frame's diffs once one frame is in.
          out_valid = ph | primed;
          if (in_last) begin
            if (cnt == CNT_FRAME_LAST) begin
              state_nxt = FLUSH;
              cnt_nxt   = '0;
            end else begin
              err_nxt    = 1'b1;
              state_nxt  = IDLE;
              cnt_nxt    = '0;
              primed_nxt = 1'b0;
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
            if (cnt == CNT_FRAME_LAST) begin
              primed_nxt = 1'b1;
            end
          end
        end
      end

      FLUSH: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (in_valid) begin
          err_nxt = 1'b1;
        end
        if (cnt == CNT_FLUSH_LAST) begin
          done_nxt   = 1'b1;
          state_nxt  = IDLE;
          cnt_nxt    = '0;
          primed_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      default: begin
        state_nxt  = IDLE;
        cnt_nxt    = '0;
        primed_nxt = 1'b0;
      end
    endcase

    // Address only matters while a twiddled diff is leaving the delay line.
    tw_addr = (out_valid && !out_sel) ? TW_AW'(tw_prod) : '0;
  end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
module tb_sdf_stage_ctrl;

  localparam int INDEX     = 4;
  localparam int TW_STRIDE = 2;
  localparam int TW_AW     = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             bf_sel, out_sel, out_valid, busy, done, err;
  logic [TW_AW-1:0] tw_addr;

  int checks   = 0;
  int failures = 0;

  sdf_stage_ctrl #(
    .INDEX    (INDEX),
    .TW_STRIDE(TW_STRIDE),
    .TW_AW    (TW_AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_last  (in_last),
    .bf_sel   (bf_sel),
    .out_sel  (out_sel),
    .out_valid(out_valid),
    .tw_addr  (tw_addr),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Packed view: {bf_sel, out_sel, out_valid, busy, err, done, tw_addr}
  function automatic logic [8:0] e(input logic bf, os, ov, bsy, er, dn, input logic [2:0] tw);
    return {bf, os, ov, bsy, er, dn, tw};
  endfunction

  function automatic logic [8:0] obs();
    return {bf_sel, out_sel, out_valid, busy, err, done, tw_addr};
  endfunction

  // One clock: apply inputs just after the edge, check settled outputs.
  // err/done seen here are the registered result of the previous cycle.
  task automatic cyc(input logic v, input logic l, input logic [8:0] exp, input string tag);
    @(posedge clk);
    #1;
    in_valid = v;
    in_last  = l;
    #1;
    check(tag, 32'(obs()), 32'(exp));
  endtask

  // nfr contiguous frames with in_last on the final sample, then the flush.
  // inj (1..INDEX) drives in_valid on that flush cycle; 0 = clean flush.
  task automatic run_frames(input int nfr, input int inj, input string tag);
    int       n_ov;
    int       c;
    logic     p, ov, er;
    logic [2:0] tw;
    n_ov = 0;
    for (int i = 1; i <= 8 * nfr; i++) begin
      c  = (i - 1) % 8;
      p  = (c >= 4);
      ov = p || (i > 8);
      tw = (!p && ov) ? 3'((c % 4) * 2) : 3'd0;
      cyc(1'b1, i == 8 * nfr, e(p, p, ov, i > 1, 1'b0, 1'b0, tw), $sformatf("%s_s%0d", tag, i));
      if (out_valid) n_ov++;
    end
    for (int k = 1; k <= 4; k++) begin
      er = (inj != 0) && (k == inj + 1);
      cyc(k == inj, 1'b0, e(1'b0, 1'b0, 1'b1, 1'b1, er, 1'b0, 3'(2 * (k - 1))),
          $sformatf("%s_f%0d", tag, k));
      if (out_valid) n_ov++;
    end
    cyc(1'b0, 1'b0, e(1'b0, 1'b0, 1'b0, 1'b0, inj == 4, 1'b1, 3'd0), {tag, "_done"});
    cyc(1'b0, 1'b0, e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0), {tag, "_quiet"});
    check({tag, "_ov_count"}, 32'(n_ov), 32'(8 * nfr - 4 + 4));
  endtask

  initial begin
    // 1. Reset held with garbage on the inputs
    in_valid = 1'b1;
    in_last  = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_hold", 32'(obs()), 32'(e(0, 0, 0, 0, 0, 0, 3'd0)));
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    // in_last alone in IDLE is ignored
    cyc(1'b0, 1'b1, e(0, 0, 0, 0, 0, 0, 3'd0), "idle_last_only");
    cyc(1'b0, 1'b0, e(0, 0, 0, 0, 0, 0, 3'd0), "idle_last_only_noerr");

    // Mid-RUN reset
    cyc(1'b1, 1'b0, e(0, 0, 0, 0, 0, 0, 3'd0), "mr_s1");
    cyc(1'b1, 1'b0, e(0, 0, 0, 1, 0, 0, 3'd0), "mr_s2");
    cyc(1'b1, 1'b0, e(0, 0, 0, 1, 0, 0, 3'd0), "mr_s3");
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mr_busy_after_rst", 32'(obs()), 32'(e(0, 0, 0, 0, 0, 0, 3'd0)));
    rst = 1'b0;
    cyc(1'b0, 1'b0, e(0, 0, 0, 0, 0, 0, 3'd0), "mr_no_done");

    // 2. Single frame + flush
    run_frames(1, 0, "one");

    // 3. Three back-to-back frames
    run_frames(3, 0, "three");

    // 4. Gap at sample 6
    cyc(1'b1, 1'b0, e(0, 0, 0, 0, 0, 0, 3'd0), "gap_s1");
    cyc(1'b1, 1'b0, e(0, 0, 0, 1, 0, 0, 3'd0), "gap_s2");
    cyc(1'b1, 1'b0, e(0, 0, 0, 1, 0, 0, 3'd0), "gap_s3");
    cyc(1'b1, 1'b0, e(0, 0, 0, 1, 0, 0, 3'd0), "gap_s4");
    cyc(1'b1, 1'b0, e(1, 1, 1, 1, 0, 0, 3'd0), "gap_s5");
    cyc(1'b0, 1'b0, e(0, 0, 0, 1, 0, 0, 3'd0), "gap_hole");
    cyc(1'b1, 1'b0, e(0, 0, 0, 0, 1, 0, 3'd0), "gap_restart");
    cyc(1'b1, 1'b0, e(0, 0, 0, 1, 0, 0, 3'd0), "gap_restart_s2");
    cyc(1'b0, 1'b0, e(0, 0, 0, 1, 0, 0, 3'd0), "gap_abandon");
    cyc(1'b0, 1'b0, e(0, 0, 0, 0, 1, 0, 3'd0), "gap_abandon_err");
    cyc(1'b0, 1'b0, e(0, 0, 0, 0, 0, 0, 3'd0), "gap_quiet");

    // 5. in_last on sample 5
    cyc(1'b1, 1'b0, e(0, 0, 0, 0, 0, 0, 3'd0), "ml_s1");
    cyc(1'b1, 1'b0, e(0, 0, 0, 1, 0, 0, 3'd0), "ml_s2");
    cyc(1'b1, 1'b0, e(0, 0, 0, 1, 0, 0, 3'd0), "ml_s3");
    cyc(1'b1, 1'b0, e(0, 0, 0, 1, 0, 0, 3'd0), "ml_s4");
    cyc(1'b1, 1'b1, e(1, 1, 1, 1, 0, 0, 3'd0), "ml_s5");
    cyc(1'b0, 1'b0, e(0, 0, 0, 0, 1, 0, 3'd0), "ml_err_idle");
    cyc(1'b0, 1'b0, e(0, 0, 0, 0, 0, 0, 3'd0), "ml_no_flush");
    cyc(1'b0, 1'b0, e(0, 0, 0, 0, 0, 0, 3'd0), "ml_no_done");

    // 6. in_valid during flush cycle 2
    run_frames(1, 2, "fl_inj");

    // IDLE in_valid with in_last
    cyc(1'b1, 1'b1, e(0, 0, 0, 0, 0, 0, 3'd0), "idle_last");
    cyc(1'b0, 1'b0, e(0, 0, 0, 0, 1, 0, 3'd0), "idle_last_err");
    cyc(1'b0, 1'b0, e(0, 0, 0, 0, 0, 0, 3'd0), "idle_last_quiet");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
